timer_ctrl_master: RTL and testbench
====================================

TIMER_CTRL_MASTER -- requirements
Module: timer_ctrl_master

Interface
REQ-001 SHALL have parameter CTRL_ITO, default 1, meaning the interrupt-enable bit written into timer control bit0.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_start  in  1  pulse: program and start the timer.
- cfg_period  in  32  period value, sampled on accepted cfg_start.
- cfg_continuous  in  1  continuous mode, sampled on accepted cfg_start.
- cfg_stop  in  1  pulse: stop the timer.
- snap_req  in  1  pulse: request a counter snapshot.
- busy  out  1  high whenever state != IDLE.
- tick  out  1  one-cycle pulse per acknowledged timeout.
- tick_count  out  32  acknowledged timeouts since last start.
- snap_value  out  32  last snapshot read.
- snap_valid  out  1  one-cycle pulse when snap_value updates.
- avm_address  out  3  timer register address.
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  timer read data, registered in the timer, valid 1 cycle after address.
- irq_in  in  1  level timer interrupt.

Function
REQ-003 SHALL make every bus write a single cycle with chipselect=1 and write_n=0, and SHALL expect no waitrequest.
REQ-004 SHALL make every bus read two cycles with chipselect=1, write_n=1 and the address held, capturing avm_readdata on the second cycle.
REQ-005 SHALL drive chipselect=0, write_n=1, address=0 and writedata=0 in IDLE and RUN.
REQ-006 SHALL use the timer register map 0=status, 1=control, 2=period_l, 3=period_h, 4=snap_l, 5=snap_h, with control bits 3=stop, 2=start, 1=cont, 0=ito.
REQ-007 SHALL implement the states IDLE, WR_STOP, WR_PERL, WR_PERH, WR_CTRL, RUN, ACK, SNAP_WR, RD_SNL0, RD_SNL1, RD_SNH0 and RD_SNH1.
REQ-008 SHALL, on cfg_start in IDLE, latch the period and mode, clear tick_count, and go IDLE->WR_PERL (addr2, period[15:0]) ->WR_PERH (addr3, period[31:16]) ->WR_CTRL (addr1, 0x4|cont<<1|CTRL_ITO) ->RUN, writing back-to-back.
REQ-009 SHALL ignore cfg_start outside IDLE.
REQ-010 SHALL use the RUN-state priority irq_in > stop (cfg_stop or stop_pend) > snap (snap_req or snap_pend).
REQ-011 SHALL, on irq_in in RUN, go to ACK, write addr0 data 0, pulse tick for 1 cycle, and increment tick_count with 32-bit wrap.
REQ-012 SHALL, after ACK, go to RUN if continuous and to IDLE if single-shot.
REQ-013 SHALL, on a stop in RUN, go to WR_STOP, write addr1 data 0x8, then go to IDLE.
REQ-014 SHALL, on a snap in RUN, go SNAP_WR (addr4 write 0) ->RD_SNL0/1 (addr4, capture low) ->RD_SNH0/1 (addr5, capture high) ->RUN.
REQ-015 SHALL update snap_value in the cycle after RD_SNH1 and pulse snap_valid in that same cycle.
REQ-016 SHALL latch cfg_stop arriving in any busy state other than RUN into stop_pend, and SHALL latch snap_req arriving in any busy state other than RUN into snap_pend.
REQ-017 SHALL clear each pending flag when it is serviced, and SHALL clear both pending flags on entry to IDLE.
REQ-018 SHALL ignore cfg_stop and snap_req in IDLE.
REQ-019 SHALL clear a pending snap without servicing it if a single-shot ACK or a stop reaches IDLE first.
REQ-020 SHALL write cfg_period=0 unchanged, without checking.

Reset
REQ-021 SHALL, while reset_n=0 at a clock edge, force state=IDLE, busy=0, tick=0, tick_count=0, snap_value=0, snap_valid=0, stop_pend=0, snap_pend=0, chipselect=0, write_n=1, address=0 and writedata=0.
REQ-022 SHALL abandon any transfer in progress on a mid-operation reset without completing it.

Structure
REQ-023 SHALL place the register address constants, control bit positions and state enum in the shared timer package.
REQ-024 SHALL be a single module, with the bus access sequencing inline in the FSM and no sub-module.

Verification
REQ-025 SHALL verify programming: cfg_start, period 0x0001_869F, cont=1 -> writes addr2=0x869F, addr3=0x0001, addr1=0x0007 on consecutive cycles, then RUN.
REQ-026 SHALL verify continuous ticks: irq_in asserted 3 times -> 3 writes addr0=0; tick_count=3; FSM returns to RUN each time.
REQ-027 SHALL verify single-shot: cont=0, one irq -> ACK write, tick, then IDLE with busy=0.
REQ-028 SHALL verify snapshot: snap_req, model returns 0x1234 at addr4 and 0x0005 at addr5 -> snap_value=0x0005_1234 with a one-cycle snap_valid.
REQ-029 SHALL verify priority: irq_in and cfg_stop in the same RUN cycle -> ACK write first, then addr1=0x8, then IDLE; snap_req during WR_CTRL -> serviced on the first RUN cycle.
REQ-030 SHALL verify reset: reset_n=0 during RD_SNL1 -> next cycle IDLE, chipselect=0, no snap_valid.

Source files
------------

// File: rtl/timer_ctrl_master_pkg.sv
// rtl/timer_ctrl_master_pkg.sv - timer register map, control bits and sequencer states
package timer_ctrl_master_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_BIT_STOP  = 3;
    localparam int CTRL_BIT_START = 2;
    localparam int CTRL_BIT_CONT  = 1;
    localparam int CTRL_BIT_ITO   = 0;

    typedef enum logic [3:0] {
        IDLE,
        WR_STOP,
        WR_PERL,
        WR_PERH,
        WR_CTRL,
        RUN,
        ACK,
        SNAP_WR,
        RD_SNL0,
        RD_SNL1,
        RD_SNH0,
        RD_SNH1
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w                 = '0;
        w[CTRL_BIT_STOP]  = stop;
        w[CTRL_BIT_START] = start;
        w[CTRL_BIT_CONT]  = cont;
        w[CTRL_BIT_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// rtl/timer_ctrl_master.sv - programs, services and snapshots an interval timer over a simple bus
// Bus outputs are a Moore decode of the state; reads hold the address for two cycles.
module timer_ctrl_master
    import timer_ctrl_master_pkg::*;
#(
    parameter bit CTRL_ITO = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        cfg_stop,
    input  logic        snap_req,
    output logic        busy,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        irq_in
);

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        cont_q, cont_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
    logic        stop_pend_q, stop_pend_d;
    logic        snap_pend_q, snap_pend_d;
    logic        stop_any, snap_any;

    assign busy       = (state_q != IDLE);
    assign tick_count = tick_count_q;
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
    assign stop_any   = cfg_stop | stop_pend_q;
    assign snap_any   = snap_req | snap_pend_q;

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        cont_d         = cont_q;
        tick_count_d   = tick_count_q;
        snap_lo_d      = snap_lo_q;
        snap_value_d   = snap_value_q;
        snap_valid_d   = 1'b0;
        stop_pend_d    = stop_pend_q;
        snap_pend_d    = snap_pend_q;
        tick           = 1'b0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = '0;
        avm_writedata  = '0;

        // Requests arriving while a bus sequence is in flight are remembered for RUN.
        if (state_q != IDLE && state_q != RUN) begin
            if (cfg_stop) stop_pend_d = 1'b1;
            if (snap_req) snap_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    period_d     = cfg_period;
                    cont_d       = cfg_continuous;
                    tick_count_d = '0;
                    state_d      = WR_PERL;
                end
            end
            WR_PERL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIOD_L;
                avm_writedata  = period_q[15:0];
                state_d        = WR_PERH;
            end
            WR_PERH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIOD_H;
                avm_writedata  = period_q[31:16];
                state_d        = WR_CTRL;
            end
            WR_CTRL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CONTROL;
                avm_writedata  = ctrl_word(1'b1, 1'b0, cont_q, CTRL_ITO);
                state_d        = RUN;
            end
            RUN: begin
                // Requests losing arbitration this cycle stay pending.
                if (irq_in) begin
                    stop_pend_d = stop_any;
                    snap_pend_d = snap_any;
                    state_d     = ACK;
                end else if (stop_any) begin
                    stop_pend_d = 1'b0;
                    snap_pend_d = snap_any;
                    state_d     = WR_STOP;
                end else if (snap_any) begin
                    snap_pend_d = 1'b0;
                    state_d     = SNAP_WR;
                end
            end
            ACK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_STATUS;
                tick           = 1'b1;
                tick_count_d   = tick_count_q + 32'd1;
                state_d        = cont_q ? RUN : IDLE;
            end
            WR_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CONTROL;
                avm_writedata  = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0);
                state_d        = IDLE;
            end
            SNAP_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_SNAP_L;
                state_d        = RD_SNL0;
            end
            RD_SNL0: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAP_L;
                state_d        = RD_SNL1;
            end
            RD_SNL1: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAP_L;
                snap_lo_d      = avm_readdata;
                state_d        = RD_SNH0;
            end
            RD_SNH0: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAP_H;
                state_d        = RD_SNH1;
            end
            RD_SNH1: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAP_H;
                snap_value_d   = {avm_readdata, snap_lo_q};
                snap_valid_d   = 1'b1;
                state_d        = RUN;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
            snap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            tick_count_q <= '0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_count_q <= tick_count_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb/tb_timer_ctrl_master.sv - directed self-checking bench for timer_ctrl_master
// A registered timer read model answers snapshot reads one cycle after the address.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        snap_req = 1'b0;
    logic        irq_in = 1'b0;
    logic [15:0] avm_readdata;
    logic        busy, tick, snap_valid;
    logic [31:0] tick_count, snap_value;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [20:0] bus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_snap_l = 16'h1234;
    logic [15:0] model_snap_h = 16'h0005;

    timer_ctrl_master #(.CTRL_ITO(1'b1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_stop       (cfg_stop),
        .snap_req       (snap_req),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .irq_in         (irq_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        avm_readdata <= (avm_chipselect && avm_address == 3'd4) ? model_snap_l :
                        (avm_chipselect && avm_address == 3'd5) ? model_snap_h : 16'h0000;

    assign bus = {avm_chipselect, avm_write_n, avm_address, avm_writedata};

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {2'b10, a, d};
    endfunction

    function automatic logic [20:0] rd(input logic [2:0] a);
        return {2'b11, a, 16'h0000};
    endfunction

    function automatic logic [20:0] idle_bus();
        return {2'b01, 19'h0};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic start_timer(input logic [31:0] p, input logic c);
        cfg_start = 1'b1; cfg_period = p; cfg_continuous = c;
        cyc();
        cfg_start = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(); cyc();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
        n_checks++; if (tick_count !== 32'h0) begin n_fail++; $display("FAIL reset_tick_count: got %h expected 0", tick_count); end
        n_checks++; if (snap_value !== 32'h0 || snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_snap: got %h/%b expected 0/0", snap_value, snap_valid); end
        n_checks++; if (bus !== idle_bus()) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", bus, idle_bus()); end
        reset_n = 1'b1;
        cyc();
        cfg_stop = 1'b1; snap_req = 1'b1;
        cyc();
        cfg_stop = 1'b0; snap_req = 1'b0;
        cyc();
        n_checks++; if (busy !== 1'b0 || bus !== idle_bus()) begin n_fail++; $display("FAIL idle_ignore: got busy %b bus %h expected 0 %h", busy, bus, idle_bus()); end
    endtask

    task automatic test_programming();
        cfg_start = 1'b1; cfg_period = 32'h0001_869F; cfg_continuous = 1'b1;
        cyc();
        cfg_start = 1'b0; cfg_period = 32'hFFFF_FFFF;
        n_checks++; if (bus !== wr(3'd2, 16'h869F) || busy !== 1'b1) begin n_fail++; $display("FAIL prog_perl: got %h busy %b expected %h", bus, busy, wr(3'd2, 16'h869F)); end
        cyc();
        n_checks++; if (bus !== wr(3'd3, 16'h0001)) begin n_fail++; $display("FAIL prog_perh: got %h expected %h", bus, wr(3'd3, 16'h0001)); end
        cyc();
        n_checks++; if (bus !== wr(3'd1, 16'h0007)) begin n_fail++; $display("FAIL prog_ctrl: got %h expected %h", bus, wr(3'd1, 16'h0007)); end
        cyc();
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL prog_run: got %h busy %b expected %h busy 1", bus, busy, idle_bus()); end
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL start_ignored_in_run: got %h busy %b expected %h busy 1", bus, busy, idle_bus()); end
    endtask

    task automatic test_continuous();
        for (int k = 0; k < 3; k++) begin
            irq_in = 1'b1;
            cyc();
            irq_in = 1'b0;
            n_checks++; if (bus !== wr(3'd0, 16'h0) || tick !== 1'b1) begin n_fail++; $display("FAIL cont_ack%0d: got %h tick %b expected %h tick 1", k, bus, tick, wr(3'd0, 16'h0)); end
            cyc();
            n_checks++; if (bus !== idle_bus() || tick !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cont_run%0d: got %h tick %b busy %b expected %h 0 1", k, bus, tick, busy, idle_bus()); end
            n_checks++; if (tick_count !== 32'(k + 1)) begin n_fail++; $display("FAIL cont_count%0d: got %0d expected %0d", k, tick_count, k + 1); end
        end
    endtask

    task automatic test_snapshot();
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        n_checks++; if (bus !== wr(3'd4, 16'h0)) begin n_fail++; $display("FAIL snap_wr: got %h expected %h", bus, wr(3'd4, 16'h0)); end
        cyc();
        n_checks++; if (bus !== rd(3'd4)) begin n_fail++; $display("FAIL snap_rdl0: got %h expected %h", bus, rd(3'd4)); end
        cyc();
        n_checks++; if (bus !== rd(3'd4)) begin n_fail++; $display("FAIL snap_rdl1: got %h expected %h", bus, rd(3'd4)); end
        cyc();
        n_checks++; if (bus !== rd(3'd5)) begin n_fail++; $display("FAIL snap_rdh0: got %h expected %h", bus, rd(3'd5)); end
        cyc();
        n_checks++; if (bus !== rd(3'd5) || snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_rdh1: got %h valid %b expected %h valid 0", bus, snap_valid, rd(3'd5)); end
        cyc();
        n_checks++; if (snap_valid !== 1'b1 || snap_value !== 32'h0005_1234) begin n_fail++; $display("FAIL snap_value: got %h valid %b expected 00051234 valid 1", snap_value, snap_valid); end
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL snap_back_to_run: got %h busy %b expected %h", bus, busy, idle_bus()); end
        cyc();
        n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_valid_pulse: got %b expected 0", snap_valid); end
    endtask

    task automatic test_priority();
        irq_in = 1'b1; cfg_stop = 1'b1;
        cyc();
        irq_in = 1'b0; cfg_stop = 1'b0;
        n_checks++; if (bus !== wr(3'd0, 16'h0) || tick !== 1'b1) begin n_fail++; $display("FAIL prio_ack_first: got %h tick %b expected %h", bus, tick, wr(3'd0, 16'h0)); end
        cyc();
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL prio_run: got %h busy %b expected %h", bus, busy, idle_bus()); end
        cyc();
        n_checks++; if (bus !== wr(3'd1, 16'h0008)) begin n_fail++; $display("FAIL prio_stop_write: got %h expected %h", bus, wr(3'd1, 16'h0008)); end
        cyc();
        n_checks++; if (busy !== 1'b0 || bus !== idle_bus()) begin n_fail++; $display("FAIL prio_idle: got busy %b bus %h expected 0 %h", busy, bus, idle_bus()); end

        model_snap_l = 16'hABCD; model_snap_h = 16'h7777;
        cfg_start = 1'b1; cfg_period = 32'hDEAD_BEEF; cfg_continuous = 1'b1;
        cyc();
        cfg_start = 1'b0;
        n_checks++; if (bus !== wr(3'd2, 16'hBEEF)) begin n_fail++; $display("FAIL prio_perl: got %h expected %h", bus, wr(3'd2, 16'hBEEF)); end
        cyc();
        n_checks++; if (bus !== wr(3'd3, 16'hDEAD)) begin n_fail++; $display("FAIL prio_perh: got %h expected %h", bus, wr(3'd3, 16'hDEAD)); end
        cyc();
        n_checks++; if (bus !== wr(3'd1, 16'h0007)) begin n_fail++; $display("FAIL prio_ctrl: got %h expected %h", bus, wr(3'd1, 16'h0007)); end
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL pend_run: got %h busy %b expected %h", bus, busy, idle_bus()); end
        cyc();
        n_checks++; if (bus !== wr(3'd4, 16'h0)) begin n_fail++; $display("FAIL pend_snap_serviced: got %h expected %h", bus, wr(3'd4, 16'h0)); end
        cyc(); cyc(); cyc(); cyc(); cyc();
        n_checks++; if (snap_valid !== 1'b1 || snap_value !== 32'h7777_ABCD) begin n_fail++; $display("FAIL pend_snap_value: got %h valid %b expected 7777abcd valid 1", snap_value, snap_valid); end
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        n_checks++; if (bus !== wr(3'd1, 16'h0008)) begin n_fail++; $display("FAIL stop_write: got %h expected %h", bus, wr(3'd1, 16'h0008)); end
        cyc();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got %b expected 0", busy); end
    endtask

    task automatic test_single_shot();
        cfg_start = 1'b1; cfg_period = 32'h0; cfg_continuous = 1'b0;
        cyc();
        cfg_start = 1'b0;
        n_checks++; if (bus !== wr(3'd2, 16'h0)) begin n_fail++; $display("FAIL ss_perl: got %h expected %h", bus, wr(3'd2, 16'h0)); end
        cyc();
        n_checks++; if (bus !== wr(3'd3, 16'h0)) begin n_fail++; $display("FAIL ss_perh: got %h expected %h", bus, wr(3'd3, 16'h0)); end
        cyc();
        n_checks++; if (bus !== wr(3'd1, 16'h0005)) begin n_fail++; $display("FAIL ss_ctrl: got %h expected %h", bus, wr(3'd1, 16'h0005)); end
        cyc();
        n_checks++; if (tick_count !== 32'h0) begin n_fail++; $display("FAIL ss_count_cleared: got %h expected 0", tick_count); end
        irq_in = 1'b1;
        cyc();
        irq_in = 1'b0; snap_req = 1'b1;
        n_checks++; if (bus !== wr(3'd0, 16'h0) || tick !== 1'b1) begin n_fail++; $display("FAIL ss_ack: got %h tick %b expected %h", bus, tick, wr(3'd0, 16'h0)); end
        cyc();
        snap_req = 1'b0;
        n_checks++; if (busy !== 1'b0 || tick !== 1'b0 || bus !== idle_bus()) begin n_fail++; $display("FAIL ss_idle: got busy %b tick %b bus %h expected 0 0 %h", busy, tick, bus, idle_bus()); end
        n_checks++; if (tick_count !== 32'h1) begin n_fail++; $display("FAIL ss_count: got %h expected 1", tick_count); end
        start_timer(32'h0000_0010, 1'b1);
        cyc();
        n_checks++; if (bus !== idle_bus() || busy !== 1'b1) begin n_fail++; $display("FAIL stale_snap_dropped: got %h busy %b expected %h", bus, busy, idle_bus()); end
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        start_timer(32'h0000_0100, 1'b1);
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        cyc(); cyc();
        n_checks++; if (bus !== rd(3'd4)) begin n_fail++; $display("FAIL mid_in_rdl1: got %h expected %h", bus, rd(3'd4)); end
        reset_n = 1'b0;
        cyc();
        n_checks++; if (busy !== 1'b0 || bus !== idle_bus() || snap_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got busy %b bus %h valid %b expected 0 %h 0", busy, bus, snap_valid, idle_bus()); end
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            seen_valid = seen_valid | snap_valid | busy;
        end
        n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL mid_abandoned: got activity %b expected 0", seen_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        test_reset();
        test_programming();
        test_continuous();
        test_snapshot();
        test_priority();
        test_single_shot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
